// File: rtl/ttl_sync_pkg.sv
// Shared helpers for the synchronous TTL-style models: the width helper and the
// reset value of the Cen edge detector.
package ttl_sync_pkg;

  // Reset to 1 so a Cen already high at reset release does not look like an edge.
  localparam logic LAST_CEN_RST = 1'b1;

  function automatic int CLOG2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ttl_pixel_shifter_sync_if.sv
// Data and control bundle for the pixel shifter: counter-decoded controls and ROM
// data in, serial pixel and status out.
interface ttl_pixel_shifter_sync_if #(
  parameter int WIDTH  = 8,
  parameter int PLANES = 2
);
  logic                      Cen;
  logic                      Latch_en;
  logic                      Load_bar;
  logic                      Clk_inh;
  logic                      Flip;
  logic [WIDTH*PLANES-1:0]   D;
  logic [PLANES-1:0]         Pix;
  logic                      Empty;
  logic                      Underrun;

  modport master (
    output Cen, Latch_en, Load_bar, Clk_inh, Flip, D,
    input  Pix, Empty, Underrun
  );

  modport slave (
    input  Cen, Latch_en, Load_bar, Clk_inh, Flip, D,
    output Pix, Empty, Underrun
  );
endinterface

// File: rtl/ttl_cen_edge.sv
// Rising-edge detector for the shared pixel clock enable; every action in the
// *_sync TTL models happens on E only.
module ttl_cen_edge
  import ttl_sync_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic Cen,
  output logic E
);

  logic last_cen;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly like the real parts sharing one clock.
  always_ff @(posedge Clk) begin
    if (Rst) last_cen <= LAST_CEN_RST;
    else     last_cen <= Cen;
  end

  assign E = Cen & ~last_cen;

endmodule

// File: rtl/ttl_pixel_shifter_sync.sv
// 74LS273 holding latch feeding one 74LS166-style PISO shifter per bitplane,
// advanced on Cen rising edges and reloaded by the counter's inverted carry.
module ttl_pixel_shifter_sync
  import ttl_sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PLANES = 2
) (
  input  logic Clk,
  input  logic Rst,
  ttl_pixel_shifter_sync_if.slave bus
);

  localparam int CW = CLOG2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic          e;
  logic          latch_ev;
  logic          load_ev;
  logic          shift_ev;
  logic          flip_q;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          underrun_q;

  ttl_cen_edge u_cen_edge (
    .Clk (Clk),
    .Rst (Rst),
    .Cen (bus.Cen),
    .E   (e)
  );

  // Clock inhibit gates load and shift but never the holding latch.
  assign latch_ev = e & bus.Latch_en;
  assign load_ev  = e & ~bus.Clk_inh & ~bus.Load_bar;
  assign shift_ev = e & ~bus.Clk_inh &  bus.Load_bar;
  assign empty    = (cnt == CNT_FULL);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      flip_q     <= 1'b0;
      cnt        <= CNT_FULL;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= shift_ev & empty;
      if (load_ev) begin
        flip_q <= bus.Flip;
        cnt    <= '0;
      end else if (shift_ev && !empty) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] shift_q;

    // Load reads hold_q before this edge's latch, giving the fetch pipeline.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        hold_q  <= '0;
        shift_q <= '0;
      end else begin
        if (latch_ev) hold_q <= bus.D[p*WIDTH +: WIDTH];
        if (load_ev)
          shift_q <= hold_q;
        else if (shift_ev)
          shift_q <= flip_q ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0};
      end
    end

    assign bus.Pix[p] = flip_q ? shift_q[0] : shift_q[WIDTH-1];
  end

  assign bus.Empty    = empty;
  assign bus.Underrun = underrun_q;

endmodule

// File: tb/tb_ttl_pixel_shifter_sync.sv
// Bench for ttl_pixel_shifter_sync: directed scenarios with literal pixel
// expectations plus randomized control traffic checked against a pixel-queue model.
module tb_ttl_pixel_shifter_sync;

  localparam int WIDTH  = 8;
  localparam int PLANES = 2;
  localparam int D_W    = WIDTH * PLANES;

  logic clk;
  logic rst;

  ttl_pixel_shifter_sync_if #(.WIDTH(WIDTH), .PLANES(PLANES)) bus ();

  ttl_pixel_shifter_sync #(.WIDTH(WIDTH), .PLANES(PLANES)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a load turns the holding register into a list of WIDTH pixels in
  // display order; each shift just advances an index into that list.
  logic [WIDTH-1:0]  m_hold [PLANES];
  logic [PLANES-1:0] m_seq  [WIDTH];
  int                m_idx;
  logic              m_last;
  logic              m_under;
  bit                cmp_on = 0;

  always @(posedge clk) begin : model
    logic [WIDTH-1:0] old_hold [PLANES];
    logic             e_now;
    if (rst) begin
      m_last  = 1'b1;
      m_idx   = WIDTH;
      m_under = 1'b0;
      for (int p = 0; p < PLANES; p++) m_hold[p] = '0;
      for (int i = 0; i < WIDTH; i++) m_seq[i] = '0;
      cmp_on  = 1;
    end else begin
      e_now   = bus.Cen && !m_last;
      m_last  = bus.Cen;
      m_under = 1'b0;
      if (e_now) begin
        for (int p = 0; p < PLANES; p++) old_hold[p] = m_hold[p];
        if (bus.Latch_en)
          for (int p = 0; p < PLANES; p++) m_hold[p] = bus.D[p*WIDTH +: WIDTH];
        if (!bus.Clk_inh) begin
          if (!bus.Load_bar) begin
            for (int i = 0; i < WIDTH; i++)
              for (int p = 0; p < PLANES; p++)
                m_seq[i][p] = bus.Flip ? old_hold[p][i] : old_hold[p][WIDTH-1-i];
            m_idx = 0;
          end else if (m_idx == WIDTH) begin
            m_under = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_pix", 32'(bus.Pix), (m_idx < WIDTH) ? 32'(m_seq[m_idx]) : 32'd0);
      check("model_empty", 32'(bus.Empty), 32'(m_idx == WIDTH));
      check("model_underrun", 32'(bus.Underrun), 32'(m_under));
    end
  end

  // One Cen pulse: controls valid while Cen is high, then Cen low for a cycle.
  task automatic ev(input bit latch, input bit ld_b, input bit inh, input bit flip,
                    input logic [D_W-1:0] d);
    @(negedge clk);
    bus.Cen = 1'b1; bus.Latch_en = latch; bus.Load_bar = ld_b;
    bus.Clk_inh = inh; bus.Flip = flip; bus.D = d;
    @(negedge clk);
    bus.Cen = 1'b0; bus.Latch_en = 1'b0; bus.Load_bar = 1'b1; bus.Clk_inh = 1'b0;
  endtask

  logic [1:0] exp_norm [WIDTH] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00};
  logic [1:0] exp_flip [WIDTH] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.Cen = 1'b1; bus.Latch_en = 1'b0; bus.Load_bar = 1'b1;
    bus.Clk_inh = 1'b0; bus.Flip = 1'b0; bus.D = '0;
    repeat (3) @(negedge clk);

    // Reset release with Cen held high: no spurious edge.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_pix", 32'(bus.Pix), 32'd0);
      check("rst_empty", 32'(bus.Empty), 32'd1);
      check("rst_underrun", 32'(bus.Underrun), 32'd0);
    end
    bus.Cen = 1'b0;
    @(negedge clk);

    // Normal order.
    ev(1, 1, 1, 0, 16'hF0AA);
    ev(0, 0, 0, 0, '0);
    check("norm_pix0", 32'(bus.Pix), 32'(exp_norm[0]));
    check("norm_empty_after_load", 32'(bus.Empty), 32'd0);
    for (int k = 1; k <= WIDTH; k++) begin
      ev(0, 1, 0, 0, '0);
      if (k < WIDTH) check("norm_pix", 32'(bus.Pix), 32'(exp_norm[k]));
      else           check("norm_empty", 32'(bus.Empty), 32'd1);
      check("norm_no_underrun", 32'(bus.Underrun), 32'd0);
    end
    ev(0, 1, 0, 0, '0);
    check("underrun_pulse", 32'(bus.Underrun), 32'd1);
    check("underrun_pix", 32'(bus.Pix), 32'd0);
    @(negedge clk);
    check("underrun_one_clk", 32'(bus.Underrun), 32'd0);

    // Flipped order; Flip toggled during shifting must not matter.
    ev(1, 1, 1, 0, 16'hF0AA);
    ev(0, 0, 0, 1, '0);
    check("flip_pix0", 32'(bus.Pix), 32'(exp_flip[0]));
    check("flip_load_clears_empty", 32'(bus.Empty), 32'd0);
    for (int k = 1; k < WIDTH; k++) begin
      ev(0, 1, 0, k[0], '0);
      check("flip_pix", 32'(bus.Pix), 32'(exp_flip[k]));
    end

    // Latch and load on one edge: shifter gets old hold, hold gets new D.
    ev(1, 1, 1, 0, 16'h8181);
    ev(1, 0, 0, 0, 16'h7E7E);
    check("pipe_pix0", 32'(bus.Pix), 32'd3);
    ev(0, 1, 0, 0, '0);
    check("pipe_pix1", 32'(bus.Pix), 32'd0);
    ev(0, 0, 0, 0, '0);
    check("pipe_new_pix0", 32'(bus.Pix), 32'd0);
    ev(0, 1, 0, 0, '0);
    check("pipe_new_pix1", 32'(bus.Pix), 32'd3);

    // Clock inhibit mid-stream.
    ev(1, 1, 1, 0, 16'hF0AA);
    ev(0, 0, 0, 0, '0);
    ev(1, 1, 0, 0, 16'h0000);
    check("inh_pre1", 32'(bus.Pix), 32'(exp_norm[1]));
    ev(0, 1, 0, 0, '0);
    check("inh_pre2", 32'(bus.Pix), 32'(exp_norm[2]));
    ev(0, 1, 1, 0, '0);
    check("inh_frozen_shift", 32'(bus.Pix), 32'(exp_norm[2]));
    ev(0, 0, 1, 1, '0);
    check("inh_frozen_load", 32'(bus.Pix), 32'(exp_norm[2]));
    check("inh_frozen_empty", 32'(bus.Empty), 32'd0);
    ev(1, 1, 1, 0, 16'h00FF);
    check("inh_frozen_latch", 32'(bus.Pix), 32'(exp_norm[2]));
    ev(0, 1, 0, 0, '0);
    check("inh_resume", 32'(bus.Pix), 32'(exp_norm[3]));
    ev(0, 0, 0, 0, '0);
    check("inh_latch_took", 32'(bus.Pix), 32'd1);

    // Random traffic, including Cen toggling every cycle and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 399) == 0);
      bus.Cen      = (c < 1500) ? 1'($urandom) : ~bus.Cen;
      bus.Latch_en = 1'($urandom);
      bus.Load_bar = ($urandom_range(0, 5) != 0);
      bus.Clk_inh  = ($urandom_range(0, 4) == 0);
      bus.Flip     = 1'($urandom);
      bus.D        = D_W'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
